// File: rtl/lc3_io_pkg.sv
// Shared definitions for the LC-3 memory-mapped console devices.
// Address map, status-register bit positions and the serializer state type.
package lc3_io_pkg;

   localparam logic [15:0] LC3_KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] LC3_KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] LC3_DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] LC3_DDR_ADDR  = 16'hFE06;

   localparam int DSR_READY_BIT = 15;
   localparam int DSR_OVF_BIT   = 0;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/lc3_uart_tx.sv
// 8N1 UART transmitter: a load pulse in IDLE captures a byte and sends one
// frame of exactly 10*CLKS_PER_BIT cycles, LSB first.
module lc3_uart_tx
   import lc3_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_tx
);

   localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_e     r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          w_baud_done;

   assign w_baud_done = (r_baud == BAUD_LAST);
   assign o_busy      = (r_state != TX_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; combinational blocks use blocking ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= TX_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            TX_IDLE: begin
               if (i_load) begin
                  r_shift <= i_data;
                  r_baud  <= '0;
                  r_state <= TX_START;
               end
            end
            TX_START: begin
               if (w_baud_done) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_state   <= TX_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            TX_DATA: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
                     r_state <= TX_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            TX_STOP: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_state <= TX_IDLE;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: r_state <= TX_IDLE;
         endcase
      end
   end

   // Line level decoded straight from state so reset forces the idle level at once.
   always_comb begin
      o_tx = 1'b1;
      case (r_state)
         TX_START: o_tx = 1'b0;
         TX_DATA:  o_tx = r_shift[0];
         default:  o_tx = 1'b1;
      endcase
   end

endmodule

// File: rtl/lc3_console_out.sv
// LC-3 console display: DDR writes are buffered in a small FIFO and sent out
// over a UART; DSR reports buffer readiness and a sticky overflow flag.
module lc3_console_out
   import lc3_io_pkg::*;
#(
   parameter logic [15:0] DSR_ADDR     = LC3_DSR_ADDR,
   parameter logic [15:0] DDR_ADDR     = LC3_DDR_ADDR,
   parameter int          FIFO_DEPTH   = 4,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        write,
   input  logic        read,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR_in,
   output logic        dev_sel,
   output logic [15:0] dev_rdata,
   output logic        tx,
   output logic        overflow
);

   localparam int          PW      = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   logic          r_write_q;
   logic          r_overflow;
   logic [7:0]    r_last_char;

   logic w_push_req;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;
   logic w_tx_busy;
   logic w_unused;

   // Reads have no side effects, so the read strobe and the upper data byte are not needed.
   assign w_unused = &{1'b0, read, MDR_in[15:8]};

   assign w_push_req = write & ~r_write_q & (MAR == DDR_ADDR);
   assign w_full     = (r_count == DEPTH_C);
   assign w_pop      = (r_count != '0) & ~w_tx_busy;
   // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & w_full & ~w_pop;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_write_q   <= 1'b0;
         r_overflow  <= 1'b0;
         r_last_char <= '0;
      end else begin
         r_write_q <= write;
         if (w_push) begin
            r_wptr      <= r_wptr + 1'b1;
            r_last_char <= MDR_in[7:0];
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by the pointers
   // and count, so resetting it would only cost logic.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wptr] <= MDR_in[7:0];
      end
   end

   lc3_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk    (clock),
      .rst_n  (reset_n),
      .i_load (w_pop),
      .i_data (r_mem[r_rptr]),
      .o_busy (w_tx_busy),
      .o_tx   (tx)
   );

   assign dev_sel  = (MAR == DSR_ADDR) | (MAR == DDR_ADDR);
   assign overflow = r_overflow;

   // NOTE: the default assignment up front keeps this block free of latches.
   always_comb begin
      dev_rdata = '0;
      if (MAR == DSR_ADDR) begin
         dev_rdata[DSR_READY_BIT] = ~w_full;
         dev_rdata[DSR_OVF_BIT]   = r_overflow;
      end else if (MAR == DDR_ADDR) begin
         dev_rdata = {8'h00, r_last_char};
      end
   end

endmodule

// File: tb/tb_lc3_console_out.sv
// Directed bench for lc3_console_out: a UART monitor decodes frames from tx
// and pops expected characters from a scoreboard filled by the stimulus.
`timescale 1ns/1ps
module tb_lc3_console_out;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam logic [15:0] DSR   = 16'hFE04;
   localparam logic [15:0] DDR   = 16'hFE06;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        write   = 1'b0;
   logic        read    = 1'b0;
   logic [15:0] MAR     = '0;
   logic [15:0] MDR_in  = '0;
   logic        dev_sel;
   logic [15:0] dev_rdata;
   logic        tx;
   logic        overflow;

   int         n_pass      = 0;
   int         n_total     = 0;
   int         frames_done = 0;
   int         last_gap    = 0;
   logic [7:0] sb_q[$];

   lc3_console_out #(
      .DSR_ADDR     (DSR),
      .DDR_ADDR     (DDR),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .write     (write),
      .read      (read),
      .MAR       (MAR),
      .MDR_in    (MDR_in),
      .dev_sel   (dev_sel),
      .dev_rdata (dev_rdata),
      .tx        (tx),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One write assertion held for 'hold' cycles, then one low cycle.
   task automatic write_mem(input logic [15:0] addr, input logic [15:0] data, input int hold);
      MAR    = addr;
      MDR_in = data;
      write  = 1'b1;
      tick(hold);
      write  = 1'b0;
      tick(1);
   endtask

   task automatic push_char(input logic [7:0] c);
      sb_q.push_back(c);
      write_mem(DDR, {8'h00, c}, 1);
   endtask

   task automatic read_check(input logic [15:0] addr, input logic [15:0] exp, input string tag);
      MAR  = addr;
      read = 1'b1;
      #1;
      check(tag, dev_rdata, exp);
      read = 1'b0;
   endtask

   task automatic wait_frames(input int target, input string tag);
      int budget = 0;
      while (frames_done < target && budget < 2000) begin
         @(posedge clock);
         budget++;
      end
      #1;
      check({tag, "_done"}, frames_done >= target, 1);
      check({tag, "_drained"}, sb_q.size(), 0);
   endtask

   // Frame decoder: each bit must hold for CPB consecutive samples.
   initial begin : uart_monitor
      int         idle_cnt;
      logic [9:0] fr;
      logic       unstable;
      logic       abort;
      logic [7:0] exp_c;
      idle_cnt = 0;
      forever begin
         @(negedge clock);
         if (reset_n !== 1'b1) begin
            idle_cnt = 0;
         end else if (tx !== 1'b0) begin
            idle_cnt++;
         end else begin
            unstable = 1'b0;
            abort    = 1'b0;
            fr       = '0;
            for (int b = 0; b < 10 && !abort; b++) begin
               for (int c = 0; c < CPB && !abort; c++) begin
                  if (b != 0 || c != 0) @(negedge clock);
                  if (reset_n !== 1'b1) abort = 1'b1;
                  else if (c == 0) fr[b] = tx;
                  else if (tx !== fr[b]) unstable = 1'b1;
               end
            end
            if (!abort) begin
               last_gap = idle_cnt;
               frames_done++;
               check("frame_stable", unstable, 0);
               check("frame_stop", fr[9], 1);
               check("frame_expected", sb_q.size() != 0, 1);
               if (sb_q.size() != 0) begin
                  exp_c = sb_q.pop_front();
                  check("frame_char", fr[8:1], exp_c);
               end
            end
            idle_cnt = 0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin : stimulus
      int base;
      int bad;

      // Reset state
      tick(3);
      check("rst_tx", tx, 1);
      check("rst_overflow", overflow, 0);
      read_check(DSR, 16'h8000, "rst_dsr");
      read_check(DDR, 16'h0000, "rst_ddr");
      reset_n = 1'b1;
      tick(2);

      // Single character, write held 3 cycles: exactly one frame
      base = frames_done;
      sb_q.push_back(8'h41);
      write_mem(DDR, 16'h0041, 3);
      wait_frames(base + 1, "single");
      tick(50);
      check("single_one_push", frames_done, base + 1);
      read_check(DDR, 16'h0041, "single_ddr");

      // Address decode: non-device and DSR writes are ignored
      base = frames_done;
      MAR = 16'h3000;
      #1;
      check("dec_sel_ram", dev_sel, 0);
      check("dec_rdata_ram", dev_rdata, 16'h0000);
      write_mem(16'h3000, 16'h0058, 1);
      MAR = DSR;
      #1;
      check("dec_sel_dsr", dev_sel, 1);
      write_mem(DSR, 16'h0058, 1);
      bad = 0;
      repeat (30) begin
         @(negedge clock);
         if (tx !== 1'b1) bad++;
      end
      tick(1);
      check("dec_tx_idle", bad, 0);
      check("dec_no_frame", frames_done, base);
      read_check(DDR, 16'h0041, "dec_ddr");
      read_check(DSR, 16'h8000, "dec_dsr");

      // Back-to-back frames are separated by one idle cycle
      base = frames_done;
      push_char(8'h61);
      push_char(8'h62);
      wait_frames(base + 2, "b2b");
      check("b2b_gap", last_gap, 1);
      tick(2);

      // Fill and overflow
      base = frames_done;
      push_char("H");
      push_char("E");
      push_char("L");
      push_char("L");
      push_char("O");
      read_check(DSR, 16'h0000, "full_dsr");
      write_mem(DDR, 16'h0021, 1);
      read_check(DSR, 16'h0001, "ovf_dsr");
      check("ovf_pin", overflow, 1);
      wait_frames(base + 5, "hello");
      read_check(DSR, 16'h8001, "ovf_sticky_dsr");
      read_check(DDR, 16'h004F, "hello_last_char");
      tick(2);

      // Reset during a frame
      base = frames_done;
      write_mem(DDR, 16'h005A, 1);
      @(posedge clock);
      #3;
      check("mid_frame_tx_low", tx, 0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_overflow", overflow, 0);
      read_check(DSR, 16'h8000, "mid_rst_dsr");
      read_check(DDR, 16'h0000, "mid_rst_ddr");
      tick(2);
      reset_n = 1'b1;
      tick(60);
      check("mid_rst_no_frame", frames_done, base);

      // Push into a full FIFO on the same edge the serializer pops
      base = frames_done;
      push_char("P");
      push_char("Q");
      push_char("R");
      push_char("S");
      push_char("T");
      read_check(DSR, 16'h0000, "simul_full_dsr");
      tick(32);
      push_char("U");
      read_check(DSR, 16'h0000, "simul_dsr");
      check("simul_overflow", overflow, 0);
      wait_frames(base + 6, "simul");
      read_check(DSR, 16'h8000, "simul_end_dsr");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
